randomizer_mc: RTL and testbench

Multi-channel Galois-XNOR LFSR noise generator with per-channel state memory, run-time seed loading and valid/ready output flow control.
- Next generation of the single-step randomizer: adds automatic channel initialisation after reset, programmable steps per sample, and channel-tagged output with back-pressure.
- Feeds dither/noise injection in the audio channel pipeline, and test-pattern sources.

---
 rtl/randomizer_mc_if.sv | 30 +++
 rtl/randomizer_mc.sv | 172 +++++++++++++++++
 tb/tb_randomizer_mc.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/randomizer_mc_if.sv
// Request/seed/output bus of the multi-channel LFSR noise generator.
// The generator is the slave; the traffic source and sink form the master.
interface randomizer_mc_if #(
    parameter int NR_CHANNELS  = 4,
    parameter int OUTPUT_WIDTH = 32
);
    localparam int CHANNEL_WIDTH = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1;

    logic                     seed_valid;
    logic [CHANNEL_WIDTH-1:0] seed_ch;
    logic [OUTPUT_WIDTH-1:0]  seed;
    logic                     rndm_valid;
    logic [CHANNEL_WIDTH-1:0] rndm_ch;
    logic                     rndm_ready;
    logic [OUTPUT_WIDTH-1:0]  rndm_out;
    logic [CHANNEL_WIDTH-1:0] rndm_out_ch;
    logic                     rndm_out_valid;
    logic                     rndm_out_ready;
    logic                     init_busy;

    modport master (
        output seed_valid, seed_ch, seed, rndm_valid, rndm_ch, rndm_out_ready,
        input  rndm_ready, rndm_out, rndm_out_ch, rndm_out_valid, init_busy
    );

    modport slave (
        input  seed_valid, seed_ch, seed, rndm_valid, rndm_ch, rndm_out_ready,
        output rndm_ready, rndm_out, rndm_out_ch, rndm_out_valid, init_busy
    );
endinterface

// File: rtl/randomizer_mc.sv
// Multi-channel Galois-XNOR LFSR noise generator: per-channel state, seed load, 1-cycle tagged output.
// Optional macro RANDOMIZER_TPDF_EN switches the output to triangular-PDF dither.
module randomizer_mc #(
    parameter int NR_CHANNELS      = 4,
    parameter int OUTPUT_WIDTH     = 32,
    parameter int STEPS_PER_SAMPLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    randomizer_mc_if.slave bus
);
    localparam int W  = OUTPUT_WIDTH;
    localparam int CW = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NR_CHANNELS - 1);

    generate
        if (OUTPUT_WIDTH < 3 || OUTPUT_WIDTH > 64) begin : g_bad_width
            $error("randomizer_mc: OUTPUT_WIDTH must be within 3..64");
        end
        if (NR_CHANNELS < 1 || NR_CHANNELS > 256) begin : g_bad_channels
            $error("randomizer_mc: NR_CHANNELS must be within 1..256");
        end
        if (STEPS_PER_SAMPLE < 1 || STEPS_PER_SAMPLE > OUTPUT_WIDTH) begin : g_bad_steps
            $error("randomizer_mc: STEPS_PER_SAMPLE must be within 1..OUTPUT_WIDTH");
        end
    endgenerate

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic logic [63:0] taps(input int t0, input int t1, input int t2,
                                         input int t3, input int t4);
        return ((64'd1 << t0) | (64'd1 << t1) | (64'd1 << t2) | (64'd1 << t3) | (64'd1 << t4))
               & ~64'd1;
    endfunction

    // Maximal-length XNOR taps (XAPP052), the top tap W itself is implicit in the shift.
    function automatic logic [W-1:0] tap_table(input int w);
        logic [63:0] m;
        case (w)
            3:  m = taps(2,0,0,0,0);     4:  m = taps(3,0,0,0,0);     5:  m = taps(3,0,0,0,0);
            6:  m = taps(5,0,0,0,0);     7:  m = taps(6,0,0,0,0);     8:  m = taps(6,5,4,0,0);
            9:  m = taps(5,0,0,0,0);     10: m = taps(7,0,0,0,0);     11: m = taps(9,0,0,0,0);
            12: m = taps(6,4,1,0,0);     13: m = taps(4,3,1,0,0);     14: m = taps(5,3,1,0,0);
            15: m = taps(14,0,0,0,0);    16: m = taps(15,13,4,0,0);   17: m = taps(14,0,0,0,0);
            18: m = taps(11,0,0,0,0);    19: m = taps(6,2,1,0,0);     20: m = taps(17,0,0,0,0);
            21: m = taps(19,0,0,0,0);    22: m = taps(21,0,0,0,0);    23: m = taps(18,0,0,0,0);
            24: m = taps(23,22,17,0,0);  25: m = taps(22,0,0,0,0);    26: m = taps(6,2,1,0,0);
            27: m = taps(5,2,1,0,0);     28: m = taps(25,0,0,0,0);    29: m = taps(27,0,0,0,0);
            30: m = taps(6,4,1,0,0);     31: m = taps(28,0,0,0,0);    32: m = taps(22,2,1,0,0);
            33: m = taps(20,0,0,0,0);    34: m = taps(27,2,1,0,0);    35: m = taps(33,0,0,0,0);
            36: m = taps(25,0,0,0,0);    37: m = taps(5,4,3,2,1);     38: m = taps(6,5,1,0,0);
            39: m = taps(35,0,0,0,0);    40: m = taps(38,21,19,0,0);  41: m = taps(38,0,0,0,0);
            42: m = taps(41,20,19,0,0);  43: m = taps(42,38,37,0,0);  44: m = taps(43,18,17,0,0);
            45: m = taps(44,42,41,0,0);  46: m = taps(45,26,25,0,0);  47: m = taps(42,0,0,0,0);
            48: m = taps(47,21,20,0,0);  49: m = taps(40,0,0,0,0);    50: m = taps(49,24,23,0,0);
            51: m = taps(50,36,35,0,0);  52: m = taps(49,0,0,0,0);    53: m = taps(52,38,37,0,0);
            54: m = taps(53,18,17,0,0);  55: m = taps(31,0,0,0,0);    56: m = taps(55,35,34,0,0);
            57: m = taps(50,0,0,0,0);    58: m = taps(39,0,0,0,0);    59: m = taps(58,38,37,0,0);
            60: m = taps(59,0,0,0,0);    61: m = taps(60,46,45,0,0);  62: m = taps(61,6,5,0,0);
            63: m = taps(62,0,0,0,0);    64: m = taps(63,61,60,0,0);
            default: m = '0;
        endcase
        return m[W-1:0];
    endfunction

    localparam logic [W-1:0] TAP = tap_table(W);

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        logic [W-1:0] n;
        n[W-1] = s[0];
        for (int i = W - 1; i >= 1; i--) begin
            n[i-1] = TAP[i] ? ~(s[i] ^ s[0]) : s[i];
        end
        if (&n) n = '0;
        return n;
    endfunction

    function automatic logic [W-1:0] lfsr_sample(input logic [W-1:0] s);
        logic [W-1:0] v;
        v = s;
        for (int k = 0; k < STEPS_PER_SAMPLE; k++) v = lfsr_step(v);
        return v;
    endfunction

    state_t        r_fsm, w_fsm_nxt;
    logic          w_run;
    logic [CW-1:0] r_init_cnt;
    logic [W-1:0]  r_state [NR_CHANNELS];
    logic [W-1:0]  r_out_p1;
    logic [CW-1:0] r_out_ch_p1;
    logic          r_vld_p1;
    logic          w_init_wr, w_adv, w_rdy, w_acc, w_req_ok, w_seed_ok;
    logic [W-1:0]  w_cur, w_new, w_out, w_seed_val;

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= ST_INIT;
        else     r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_run     = 1'b0;
        case (r_fsm)
            ST_INIT: if (r_init_cnt == LAST_CH) w_fsm_nxt = ST_RUN;
            ST_RUN:  w_run = !rst;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                   r_init_cnt <= '0;
        else if (r_fsm == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
    end

    assign w_init_wr  = (r_fsm == ST_INIT) && !rst;
    assign w_adv      = !r_vld_p1 || bus.rndm_out_ready;
    assign w_rdy      = w_run && w_adv;
    assign w_acc      = bus.rndm_valid && w_rdy;
    assign w_req_ok   = w_acc && (32'(bus.rndm_ch) < NR_CHANNELS);
    assign w_seed_ok  = w_run && bus.seed_valid && (32'(bus.seed_ch) < NR_CHANNELS);
    assign w_seed_val = (&bus.seed) ? '0 : bus.seed;
    assign w_cur      = r_state[bus.rndm_ch];
    assign w_new      = lfsr_sample(w_cur);

    // Seed beats the request for the state write; the sample itself uses the old state.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NR_CHANNELS; n++) begin
            if (w_init_wr && r_init_cnt == CW'(n))         r_state[n] <= W'(n);
            else if (w_seed_ok && bus.seed_ch == CW'(n))   r_state[n] <= w_seed_val;
            else if (w_req_ok && bus.rndm_ch == CW'(n))    r_state[n] <= w_new;
        end
    end

`ifdef RANDOMIZER_TPDF_EN
    logic [W-1:0]        r_prev [NR_CHANNELS];
    logic signed [W-1:0] w_new_s, w_prev_s;

    assign w_new_s  = w_new;
    assign w_prev_s = r_prev[bus.rndm_ch];
    assign w_out    = (w_new_s >>> 1) + (w_prev_s >>> 1);

    always_ff @(posedge clk) begin
        for (int n = 0; n < NR_CHANNELS; n++) begin
            if (w_init_wr && r_init_cnt == CW'(n))         r_prev[n] <= '0;
            else if (w_seed_ok && bus.seed_ch == CW'(n))   r_prev[n] <= '0;
            else if (w_req_ok && bus.rndm_ch == CW'(n))    r_prev[n] <= w_cur;
        end
    end
`else
    assign w_out = w_new;
`endif

    // Output stage p1: one cycle after acceptance, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_out_p1    <= '0;
            r_out_ch_p1 <= '0;
        end else if (w_adv) begin
            r_vld_p1 <= w_req_ok;
            if (w_req_ok) begin
                r_out_p1    <= w_out;
                r_out_ch_p1 <= bus.rndm_ch;
            end
        end
    end

    assign bus.rndm_ready     = w_rdy;
    assign bus.rndm_out       = r_out_p1;
    assign bus.rndm_out_ch    = r_out_ch_p1;
    assign bus.rndm_out_valid = r_vld_p1;
    assign bus.init_busy      = rst || (r_fsm == ST_INIT);
endmodule

// File: tb/tb_randomizer_mc.sv
// Bench for randomizer_mc: two instances (W=4 N=2 STEPS=1, W=4 N=3 STEPS=2) against a
// behavioural model, plus hand-computed sample values.
module tb_randomizer_mc;
    localparam int W  = 4;
    localparam int N0 = 2;
    localparam int N1 = 3;
    localparam int S0 = 1;
    localparam int S1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst_v;
    logic [1:0]   i_sv, i_rv, i_ordy;
    logic [1:0]   i_sch [2];
    logic [1:0]   i_rch [2];
    logic [W-1:0] i_seed [2];
    logic [1:0]   o_rdy, o_vld, o_busy;
    logic [W-1:0] o_out [2];
    logic [1:0]   o_ch [2];

    randomizer_mc_if #(.NR_CHANNELS(N0), .OUTPUT_WIDTH(W)) bus0 ();
    randomizer_mc_if #(.NR_CHANNELS(N1), .OUTPUT_WIDTH(W)) bus1 ();

    randomizer_mc #(.NR_CHANNELS(N0), .OUTPUT_WIDTH(W), .STEPS_PER_SAMPLE(S0))
        dut0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
    randomizer_mc #(.NR_CHANNELS(N1), .OUTPUT_WIDTH(W), .STEPS_PER_SAMPLE(S1))
        dut1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));

    assign bus0.seed_valid     = i_sv[0];
    assign bus0.seed_ch        = i_sch[0][0];
    assign bus0.seed           = i_seed[0];
    assign bus0.rndm_valid     = i_rv[0];
    assign bus0.rndm_ch        = i_rch[0][0];
    assign bus0.rndm_out_ready = i_ordy[0];
    assign bus1.seed_valid     = i_sv[1];
    assign bus1.seed_ch        = i_sch[1];
    assign bus1.seed           = i_seed[1];
    assign bus1.rndm_valid     = i_rv[1];
    assign bus1.rndm_ch        = i_rch[1];
    assign bus1.rndm_out_ready = i_ordy[1];

    assign o_rdy[0]  = bus0.rndm_ready;
    assign o_vld[0]  = bus0.rndm_out_valid;
    assign o_busy[0] = bus0.init_busy;
    assign o_out[0]  = bus0.rndm_out;
    assign o_ch[0]   = {1'b0, bus0.rndm_out_ch};
    assign o_rdy[1]  = bus1.rndm_ready;
    assign o_vld[1]  = bus1.rndm_out_valid;
    assign o_busy[1] = bus1.init_busy;
    assign o_out[1]  = bus1.rndm_out;
    assign o_ch[1]   = bus1.rndm_out_ch;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // W=4 XNOR LFSR with tap bit 3: shift right, feed bit0 to the top, and when bit0
    // is 0 the XNOR inverts the bit landing in position 2.
    function automatic logic [W-1:0] mstep(input logic [W-1:0] s);
        logic [W-1:0] n;
        n = (s >> 1) | (W'(s[0]) << (W - 1));
        if (!s[0]) n = n ^ 4'b0100;
        if (n == 4'hF) n = '0;
        return n;
    endfunction

    bit           m_run [2];
    int           m_cnt [2];
    logic [W-1:0] m_st  [2][4];
    bit           m_vld [2];
    logic [W-1:0] m_out [2];
    int           m_och [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int nch, ch, sch, stp;
            logic [W-1:0] nv;
            nch = (k == 0) ? N0 : N1;
            stp = (k == 0) ? S0 : S1;
            ch  = (k == 0) ? int'(i_rch[0][0]) : int'(i_rch[1]);
            sch = (k == 0) ? int'(i_sch[0][0]) : int'(i_sch[1]);
            if (rst_v[k]) begin
                m_run[k] = 1'b0;
                m_cnt[k] = 0;
                m_vld[k] = 1'b0;
                m_out[k] = '0;
                m_och[k] = 0;
            end else if (!m_run[k]) begin
                m_st[k][m_cnt[k]] = W'(m_cnt[k]);
                m_cnt[k]++;
                if (m_cnt[k] == nch) m_run[k] = 1'b1;
            end else begin
                if (!m_vld[k] || i_ordy[k]) begin
                    m_vld[k] = 1'b0;
                    if (i_rv[k] && ch < nch) begin
                        nv = m_st[k][ch];
                        for (int s = 0; s < stp; s++) nv = mstep(nv);
                        m_out[k] = nv;
                        m_och[k] = ch;
                        m_vld[k] = 1'b1;
                        m_st[k][ch] = nv;
                    end
                end
                if (i_sv[k] && sch < nch) m_st[k][sch] = (i_seed[k] == 4'hF) ? '0 : i_seed[k];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_busy%0d", k), o_busy[k], rst_v[k] || !m_run[k]);
                chk($sformatf("model_ready%0d", k), o_rdy[k],
                    !rst_v[k] && m_run[k] && (!m_vld[k] || i_ordy[k]));
                chk($sformatf("model_valid%0d", k), o_vld[k], m_vld[k]);
                if (m_vld[k]) begin
                    chk($sformatf("model_out%0d", k), o_out[k], m_out[k]);
                    chk($sformatf("model_tag%0d", k), o_ch[k], m_och[k]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, b1, dups, fifteens;
        logic [W-1:0] vals [15];

        rst_v  = 2'b11;
        i_sv   = '0;
        i_rv   = '0;
        i_ordy = 2'b11;
        for (int k = 0; k < 2; k++) begin
            i_sch[k]  = '0;
            i_rch[k]  = '0;
            i_seed[k] = '0;
        end
        cyc();
        cyc();
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", o_vld[k], 0);
            chk("rst_out", o_out[k], 0);
            chk("rst_tag", o_ch[k], 0);
            chk("rst_ready", o_rdy[k], 0);
            chk("rst_busy", o_busy[k], 1);
        end

        rst_v = 2'b00;
        #1;
        b0 = 0;
        b1 = 0;
        for (int i = 0; i < 6; i++) begin
            b0 += int'(o_busy[0]);
            b1 += int'(o_busy[1]);
            cyc();
        end
        chk("init_cycles_n2", b0, 2);
        chk("init_cycles_n3", b1, 3);
        chk("ready_after_init0", o_rdy[0], 1);
        chk("ready_after_init1", o_rdy[1], 1);

        i_rv[0] = 1'b1; i_rch[0] = 2'd0;
        cyc();
        chk("seq_out1", o_out[0], 4); chk("seq_tag1", o_ch[0], 0); chk("seq_vld1", o_vld[0], 1);
        cyc();
        chk("seq_out2", o_out[0], 6); chk("seq_tag2", o_ch[0], 0);
        i_rch[0] = 2'd1;
        cyc();
        chk("seq_out3", o_out[0], 8); chk("seq_tag3", o_ch[0], 1);
        i_rv[0] = 1'b0;
        cyc();
        chk("seq_idle", o_vld[0], 0);

        i_sv[0] = 1'b1; i_sch[0] = 2'd0; i_seed[0] = 4'd0;
        cyc();
        i_sv[0] = 1'b0;
        i_rv[0] = 1'b1; i_rch[0] = 2'd0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            vals[i] = o_out[0];
            chk("period_vld", o_vld[0], 1);
        end
        i_rv[0] = 1'b0;
        cyc();
        dups = 0;
        fifteens = 0;
        for (int i = 0; i < 15; i++) begin
            if (vals[i] == 4'hF) fifteens++;
            for (int j = i + 1; j < 15; j++) if (vals[i] == vals[j]) dups++;
        end
        chk("period_distinct", dups, 0);
        chk("period_no_lockup", fifteens, 0);
        chk("period_first", vals[0], 4);
        chk("period_last", vals[14], 0);

        i_ordy[0] = 1'b0; i_rv[0] = 1'b1; i_rch[0] = 2'd0;
        cyc();
        chk("bp_first", o_out[0], 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", o_out[0], 4);
            chk("bp_hold_vld", o_vld[0], 1);
            chk("bp_ready", o_rdy[0], 0);
            cyc();
        end
        i_ordy[0] = 1'b1;
        cyc();
        chk("bp_release", o_out[0], 6);
        i_rv[0] = 1'b0;
        cyc();

        i_sv[0] = 1'b1; i_sch[0] = 2'd0; i_seed[0] = 4'd0;
        cyc();
        i_seed[0] = 4'hF; i_rv[0] = 1'b1; i_rch[0] = 2'd0;
        cyc();
        chk("seed_same_cycle", o_out[0], 4);
        i_sv[0] = 1'b0;
        cyc();
        chk("seed_ones_as_zero", o_out[0], 4);
        i_rv[0] = 1'b0;
        cyc();

        i_rv[1] = 1'b1; i_rch[1] = 2'd0;
        cyc();
        chk("steps2_first", o_out[1], 6);
        i_rch[1] = 2'd3;
        cyc();
        chk("bad_channel", o_vld[1], 0);
        i_rch[1] = 2'd0;
        cyc();
        chk("steps2_second", o_out[1], 11);
        cyc();
        rst_v[1] = 1'b1;
        cyc();
        chk("midrst_valid", o_vld[1], 0);
        chk("midrst_busy", o_busy[1], 1);
        chk("midrst_ready", o_rdy[1], 0);
        i_rv[1] = 1'b0;
        rst_v[1] = 1'b0;
        #1;
        b1 = 0;
        for (int i = 0; i < 5; i++) begin
            b1 += int'(o_busy[1]);
            cyc();
        end
        chk("midrst_init_cycles", b1, 3);
        i_rv[1] = 1'b1; i_rch[1] = 2'd0;
        cyc();
        chk("midrst_reinit", o_out[1], 6);
        i_rv[1] = 1'b0;
        cyc();

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                i_rv[k]   = ($urandom_range(0, 3) != 0);
                i_ordy[k] = ($urandom_range(0, 3) != 0);
                i_rch[k]  = (k == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
                i_sv[k]   = ($urandom_range(0, 9) == 0);
                i_sch[k]  = (k == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
                i_seed[k] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                rst_v[k]  = ($urandom_range(0, 399) == 0);
            end
            cyc();
        end

        rst_v  = 2'b00;
        i_rv   = '0;
        i_sv   = '0;
        i_ordy = 2'b11;
        cyc();
        cyc();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
